// File: rtl/tcdm_bank_ctrl.sv
// Per-bank TCDM controller: unpacks xbar requests, drives a word-only SRAM, emulates byte enables by RMW.
// Optional performance counters are enabled with `define TCDM_BANK_CTRL_PERF_EN.
module tcdm_bank_ctrl #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned RespLat   = 1,
  localparam int unsigned BeWidth      = DataWidth / 8,
  localparam int unsigned ReqDataWidth = 1 + BeWidth + AddrWidth + DataWidth
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ReqDataWidth-1:0] wdata_i,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    sram_req_o,
  output logic                    sram_we_o,
  output logic [AddrWidth-1:0]    sram_addr_o,
  output logic [DataWidth-1:0]    sram_wdata_o,
  input  logic [DataWidth-1:0]    sram_rdata_i
`ifdef TCDM_BANK_CTRL_PERF_EN
  ,
  input  logic                    clr_cnt_i,
  output logic [31:0]             cnt_rd_o,
  output logic [31:0]             cnt_wr_o,
  output logic [31:0]             cnt_rmw_o
`endif
);

  typedef enum logic {IDLE, RMW} state_e;

  state_e state_q, state_d;

  logic                 req_wen;
  logic [BeWidth-1:0]   req_be;
  logic [AddrWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_data;
  logic                 xfer;
  logic                 rd_push;
  logic                 rmw_start;

  logic [BeWidth-1:0]   be_hold;
  logic [AddrWidth-1:0] addr_hold;
  logic [DataWidth-1:0] data_hold;
  logic                 vld_p0;

  assign {req_wen, req_be, req_addr, req_data} = wdata_i;

  // Bytes with be set come from the held request, the rest from the word just read.
  function automatic logic [DataWidth-1:0] rmw_merge(input logic [BeWidth-1:0]   be,
                                                     input logic [DataWidth-1:0] new_d,
                                                     input logic [DataWidth-1:0] old_d);
    logic [DataWidth-1:0] m;
    m = old_d;
    for (int i = 0; i < BeWidth; i++) begin
      if (be[i]) m[8*i +: 8] = new_d[8*i +: 8];
    end
    return m;
  endfunction

  assign gnt_o = (state_q == IDLE) && !rst_i;
  assign xfer  = req_i && gnt_o;

  always_comb begin
    state_d      = state_q;
    sram_req_o   = 1'b0;
    sram_we_o    = 1'b0;
    sram_addr_o  = req_addr;
    sram_wdata_o = req_data;
    rd_push      = 1'b0;
    rmw_start    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          if (!req_wen) begin
            sram_req_o = 1'b1;
            rd_push    = 1'b1;
          end else if (&req_be) begin
            sram_req_o = 1'b1;
            sram_we_o  = 1'b1;
          end else if (|req_be) begin
            sram_req_o = 1'b1;
            rmw_start  = 1'b1;
            state_d    = RMW;
          end
        end
      end
      RMW: begin
        sram_req_o   = 1'b1;
        sram_we_o    = 1'b1;
        sram_addr_o  = addr_hold;
        sram_wdata_o = rmw_merge(be_hold, data_hold, sram_rdata_i);
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A reset cycle never touches the SRAM, so an in-flight RMW leaves the old word intact.
    if (rst_i) begin
      sram_req_o = 1'b0;
      sram_we_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i) begin
    if (rmw_start) begin
      be_hold   <= req_be;
      addr_hold <= req_addr;
      data_hold <= req_data;
    end
  end

  // Stage 0: read marker registered at grant
  always_ff @(posedge clk_i) begin
    if (rst_i) vld_p0 <= 1'b0;
    else       vld_p0 <= rd_push;
  end

  if (RespLat == 1) begin : g_lat1
    assign rdata_o = (vld_p0 && !rst_i) ? sram_rdata_i : '0;
  end else begin : g_pipe
    logic [RespLat-1:1] vld_pn;
    logic [DataWidth-1:0] data_pn [RespLat-1:1];

    // Stage 1..RespLat-1: SRAM data joins the valid flag and shifts to the output
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        vld_pn <= '0;
      end else begin
        vld_pn[1] <= vld_p0;
        for (int k = 2; k < RespLat; k++) vld_pn[k] <= vld_pn[k-1];
      end
    end

    always_ff @(posedge clk_i) begin
      data_pn[1] <= sram_rdata_i;
      for (int k = 2; k < RespLat; k++) data_pn[k] <= data_pn[k-1];
    end

    assign rdata_o = (vld_pn[RespLat-1] && !rst_i) ? data_pn[RespLat-1] : '0;
  end

`ifdef TCDM_BANK_CTRL_PERF_EN
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_cnt_i) begin
      cnt_rd_o  <= '0;
      cnt_wr_o  <= '0;
      cnt_rmw_o <= '0;
    end else begin
      if (xfer && !req_wen)          cnt_rd_o  <= cnt_rd_o + 32'd1;
      if (xfer && req_wen && |req_be) cnt_wr_o  <= cnt_wr_o + 32'd1;
      if (rmw_start)                 cnt_rmw_o <= cnt_rmw_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_tcdm_bank_ctrl.sv
// Directed self-checking bench for tcdm_bank_ctrl: one RespLat=1 bank and one RespLat=3 bank,
// each backed by a behavioural 1-cycle-latency SRAM.
module tb_tcdm_bank_ctrl;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int RW = 1 + BW + AW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req1, gnt1, s1_req, s1_we;
  logic [RW-1:0] wd1;
  logic [DW-1:0] rd1, s1_wdata, s1_rq;
  logic [AW-1:0] s1_addr;
  logic          req3, gnt3, s3_req, s3_we;
  logic [RW-1:0] wd3;
  logic [DW-1:0] rd3, s3_wdata, s3_rq;
  logic [AW-1:0] s3_addr;
`ifdef TCDM_BANK_CTRL_PERF_EN
  logic        clr1, clr3;
  logic [31:0] cnt1_rd, cnt1_wr, cnt1_rmw, cnt3_rd, cnt3_wr, cnt3_rmw;
`endif

  tcdm_bank_ctrl #(.AddrWidth(AW), .DataWidth(DW), .RespLat(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .req_i(req1), .gnt_o(gnt1), .wdata_i(wd1), .rdata_o(rd1),
    .sram_req_o(s1_req), .sram_we_o(s1_we), .sram_addr_o(s1_addr), .sram_wdata_o(s1_wdata),
    .sram_rdata_i(s1_rq)
`ifdef TCDM_BANK_CTRL_PERF_EN
    , .clr_cnt_i(clr1), .cnt_rd_o(cnt1_rd), .cnt_wr_o(cnt1_wr), .cnt_rmw_o(cnt1_rmw)
`endif
  );

  tcdm_bank_ctrl #(.AddrWidth(AW), .DataWidth(DW), .RespLat(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .gnt_o(gnt3), .wdata_i(wd3), .rdata_o(rd3),
    .sram_req_o(s3_req), .sram_we_o(s3_we), .sram_addr_o(s3_addr), .sram_wdata_o(s3_wdata),
    .sram_rdata_i(s3_rq)
`ifdef TCDM_BANK_CTRL_PERF_EN
    , .clr_cnt_i(clr3), .cnt_rd_o(cnt3_rd), .cnt_wr_o(cnt3_wr), .cnt_rmw_o(cnt3_rmw)
`endif
  );

  logic [DW-1:0] mem1 [0:(1<<AW)-1];
  logic [DW-1:0] mem3 [0:(1<<AW)-1];
  int wr_cnt1 = 0;

  always @(posedge clk) begin
    if (s1_req) begin
      if (s1_we) mem1[s1_addr] <= s1_wdata;
      else       s1_rq <= mem1[s1_addr];
    end
    if (s1_req && s1_we) wr_cnt1 <= wr_cnt1 + 1;
  end

  always @(posedge clk) begin
    if (s3_req) begin
      if (s3_we) mem3[s3_addr] <= s3_wdata;
      else       s3_rq <= mem3[s3_addr];
    end
  end

  int total  = 0;
  int passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs === exp) passed++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [RW-1:0] pk(input logic w, input logic [BW-1:0] be,
                                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {w, be, a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read1(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    req1 = 1'b1;
    wd1  = pk(1'b0, '0, a, '0);
    tick();
    req1 = 1'b0;
    @(negedge clk);
    check(tag, rd1, exp);
    tick();
  endtask

  logic [BW-1:0] be_t  [4] = '{4'h1, 4'h2, 4'h4, 4'h8};
  logic [DW-1:0] d_t   [4] = '{32'h00000011, 32'h00002200, 32'h00330000, 32'h44000000};
  logic [DW-1:0] mrg_t [4] = '{32'hDEADAB11, 32'hDEAD2211, 32'hDE332211, 32'h44332211};

  logic          rq_t [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic          wn_t [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic [AW-1:0] ad_t [8] = '{10'd1, 10'd2, 10'd9, 10'd3, 10'd0, 10'd0, 10'd0, 10'd0};
  logic [DW-1:0] ex_t [8] = '{32'h0, 32'h0, 32'h0, 32'hA1A1A1A1, 32'hB2B2B2B2, 32'h0,
                              32'hC3C3C3C3, 32'h0};

  initial begin
    int wc0;
    req1 = 1'b1;
    wd1  = pk(1'b0, '0, 10'd5, '0);
    req3 = 1'b0;
    wd3  = '0;
`ifdef TCDM_BANK_CTRL_PERF_EN
    clr1 = 1'b0;
    clr3 = 1'b0;
`endif

    @(negedge clk);
    check("rst_gnt", gnt1, 0);
    check("rst_sram_req", s1_req, 0);
    check("rst_rdata", rd1, 0);
    tick();
    rst  = 1'b0;
    req1 = 1'b0;
    tick();

    // full write then read of addr 5
    req1 = 1'b1;
    wd1  = pk(1'b1, 4'hF, 10'd5, 32'hDEADBEEF);
    @(negedge clk);
    check("t1_wr_gnt", gnt1, 1);
    check("t1_wr_we", s1_we, 1);
    check("t1_wr_data", s1_wdata, 32'hDEADBEEF);
    tick();
    wd1 = pk(1'b0, '0, 10'd5, '0);
    @(negedge clk);
    check("t1_rd_gnt", gnt1, 1);
    check("t1_rdata_early", rd1, 0);
    tick();
    req1 = 1'b0;
    @(negedge clk);
    check("t1_rdata", rd1, 32'hDEADBEEF);
    tick();
    @(negedge clk);
    check("t1_rdata_after", rd1, 0);
    tick();

    // partial write be=0x2
    req1 = 1'b1;
    wd1  = pk(1'b1, 4'h2, 10'd5, 32'h0000AB00);
    @(negedge clk);
    check("t2_gnt", gnt1, 1);
    check("t2_rd_issue", {s1_req, s1_we}, 2'b10);
    tick();
    req1 = 1'b0;
    @(negedge clk);
    check("t2_rmw_gnt", gnt1, 0);
    check("t2_rmw_we", s1_we, 1);
    check("t2_rmw_addr", s1_addr, 5);
    check("t2_rmw_data", s1_wdata, 32'hDEADABEF);
    tick();
    read1(10'd5, 32'hDEADABEF, "t2_readback");

    // four back-to-back partial writes with req held
    wc0  = wr_cnt1;
    req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wd1 = pk(1'b1, be_t[i], 10'd5, d_t[i]);
      @(negedge clk);
      check("t3_gnt", gnt1, 1);
      tick();
      @(negedge clk);
      check("t3_rmw_gnt", gnt1, 0);
      check("t3_merge", s1_wdata, mrg_t[i]);
      tick();
    end
    req1 = 1'b0;
    check("t3_wr_cnt", wr_cnt1 - wc0, 4);
    read1(10'd5, 32'h44332211, "t3_readback");

    // be=0 write is granted but does not touch the SRAM
    req1 = 1'b1;
    wd1  = pk(1'b1, 4'hF, 10'd7, 32'h12345678);
    tick();
    wd1 = pk(1'b1, 4'h0, 10'd7, 32'hFFFFFFFF);
    @(negedge clk);
    check("t4_gnt", gnt1, 1);
    check("t4_sram_req", s1_req, 0);
    tick();
    read1(10'd7, 32'h12345678, "t4_readback");

    // reset during the RMW cycle drops the write
    req1 = 1'b1;
    wd1  = pk(1'b1, 4'hF, 10'd5, 32'hDEADBEEF);
    tick();
    wd1 = pk(1'b1, 4'h2, 10'd5, 32'h0000AB00);
    tick();
    req1 = 1'b0;
    rst  = 1'b1;
    @(negedge clk);
    check("t5_gnt", gnt1, 0);
    check("t5_sram_req", s1_req, 0);
    check("t5_rdata", rd1, 0);
    tick();
    rst = 1'b0;
    read1(10'd5, 32'hDEADBEEF, "t5_readback");

    // RespLat=3 bank: preload, then reads interleaved with a write
    req3 = 1'b1;
    wd3  = pk(1'b1, 4'hF, 10'd1, 32'hA1A1A1A1);
    tick();
    wd3 = pk(1'b1, 4'hF, 10'd2, 32'hB2B2B2B2);
    tick();
    wd3 = pk(1'b1, 4'hF, 10'd3, 32'hC3C3C3C3);
    tick();
    req3 = 1'b0;
`ifdef TCDM_BANK_CTRL_PERF_EN
    clr3 = 1'b1;
    tick();
    clr3 = 1'b0;
    check("t6_cnt_wr_pre", cnt3_wr, 0);
`endif
    for (int c = 0; c < 8; c++) begin
      req3 = rq_t[c];
      wd3  = pk(wn_t[c], wn_t[c] ? 4'hF : 4'h0, ad_t[c], 32'h99999999);
      @(negedge clk);
      check($sformatf("t6_rdata_c%0d", c), rd3, ex_t[c]);
      tick();
    end
`ifdef TCDM_BANK_CTRL_PERF_EN
    check("t6_cnt_rd", cnt3_rd, 3);
    check("t6_cnt_wr", cnt3_wr, 1);
    check("t6_cnt_rmw", cnt3_rmw, 0);
    clr3 = 1'b1;
    tick();
    clr3 = 1'b0;
    check("t6_clr_rd", cnt3_rd, 0);
    check("t6_clr_wr", cnt3_wr, 0);
    check("t6_clr_rmw", cnt3_rmw, 0);
    check("t6_cnt1_rd", cnt1_rd, 1);
    check("t6_cnt1_wr", cnt1_wr, 0);
    check("t6_cnt1_rmw", cnt1_rmw, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
